// File: rtl/write_arbiter_pkg.sv
// rtl/write_arbiter_pkg.sv - shared write-arbiter encodings and index helpers
package write_arbiter_pkg;

    localparam int SEL_W     = 4;
    localparam int MAX_PORTS = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } sched_state_e;

    function automatic logic [MAX_PORTS-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [MAX_PORTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/write_rr_scheduler_rr_pick.sv
// rtl/write_rr_scheduler_rr_pick.sv - rotate-priority finder: first unmasked requester at or after ptr
module rr_pick
    import write_arbiter_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic [N-1:0]     excl_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [N-1:0]     cand;
    logic [SEL_W-1:0] cidx;
    int               c;

    assign cand = req_i & ~excl_i;

    // Walk from the farthest offset down so the nearest hit to ptr is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cidx    = '0;
        c       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(ptr_i) + k;
            if (c >= N) begin
                c = c - N;
            end
            cidx = SEL_W'(c);
            if (cand[cidx]) begin
                found_o = 1'b1;
                idx_o   = cidx;
            end
        end
    end

endmodule

// File: rtl/write_rr_scheduler.sv
// rtl/write_rr_scheduler.sv - packet-locked round-robin write scheduler; WR_SCHED_TIMEOUT_EN adds a beat limit
module write_rr_scheduler
    import write_arbiter_pkg::*;
#(
    parameter int num_of_ports  = 16,
    parameter int max_pkt_beats = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [num_of_ports-1:0] wr_req,
    input  logic [num_of_ports-1:0] wr_last,
    input  logic                    sram_ready,
    output logic                    enable,
    output logic [SEL_W-1:0]        select,
    output logic [num_of_ports-1:0] grant_onehot,
    output logic                    beat_accept,
    output logic                    timeout_err
);

    sched_state_e            state_q;
    logic [SEL_W-1:0]        select_q;
    logic [SEL_W-1:0]        rr_ptr_q;
    logic [num_of_ports-1:0] grant_q;

    logic                    busy;
    logic                    timeout_fire;
    logic                    pkt_done;
    logic [SEL_W-1:0]        next_ptr;
    logic [SEL_W-1:0]        pick_ptr;
    logic [num_of_ports-1:0] pick_excl;
    logic                    pick_found;
    logic [SEL_W-1:0]        pick_idx;
    logic [MAX_PORTS-1:0]    sel_oh;
    logic [MAX_PORTS-1:0]    pick_oh;

    assign busy        = (state_q == ST_BUSY);
    assign beat_accept = busy & wr_req[select_q] & sram_ready & ~rst;
    assign pkt_done    = beat_accept & (wr_last[select_q] | timeout_fire);
    assign next_ptr    = wrap_inc(select_q, num_of_ports);
    assign sel_oh      = idx_to_onehot(select_q);
    assign pick_oh     = idx_to_onehot(pick_idx);

    // While busy, arbitration only matters on the finishing beat, so the finisher is masked out.
    assign pick_ptr  = busy ? next_ptr : rr_ptr_q;
    assign pick_excl = busy ? sel_oh[num_of_ports-1:0] : '0;

    rr_pick #(.N(num_of_ports)) u_rr_pick (
        .req_i   (wr_req),
        .ptr_i   (pick_ptr),
        .excl_i  (pick_excl),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

`ifdef WR_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(max_pkt_beats) + 1;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    assign timeout_fire = beat_accept & ~wr_last[select_q] & (cnt_q == CNT_W'(max_pkt_beats - 1));
    assign timeout_err  = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
            if (!busy || pkt_done) begin
                cnt_q <= '0;
            end else if (beat_accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
`else
    assign timeout_fire = (max_pkt_beats < 0);
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            select_q <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q  <= ST_BUSY;
                        select_q <= pick_idx;
                        grant_q  <= pick_oh[num_of_ports-1:0];
                    end
                end
                ST_BUSY: begin
                    if (pkt_done) begin
                        rr_ptr_q <= next_ptr;
                        if (pick_found) begin
                            select_q <= pick_idx;
                            grant_q  <= pick_oh[num_of_ports-1:0];
                        end else begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign enable       = busy;
    assign select       = select_q;
    assign grant_onehot = grant_q;

endmodule

// File: tb/tb_write_rr_scheduler.sv
// tb/tb_write_rr_scheduler.sv - directed self-checking bench for write_rr_scheduler
module tb_write_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] wr_req;
    logic [15:0] wr_last;
    logic        sram_ready;
    logic        enable;
    logic [3:0]  select;
    logic [15:0] grant_onehot;
    logic        beat_accept;
    logic        timeout_err;

    int n_total = 0;
    int n_pass  = 0;

    write_rr_scheduler #(.num_of_ports(16), .max_pkt_beats(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .wr_last      (wr_last),
        .sram_ready   (sram_ready),
        .enable       (enable),
        .select       (select),
        .grant_onehot (grant_onehot),
        .beat_accept  (beat_accept),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wr_req  = '0;
        wr_last = '0;
        next();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        wr_req     = 16'hFFFF;
        wr_last    = '0;
        sram_ready = 1'b1;

        // 1: reset held with all ports requesting
        for (int i = 0; i < 3; i++) begin
            next();
            check("rst_enable", enable, 0);
            check("rst_select", select, 0);
            check("rst_grant", grant_onehot, 0);
            check("rst_accept", beat_accept, 0);
            check("rst_timeout", timeout_err, 0);
        end
        rst    = 1'b0;
        wr_req = '0;
        next();
        check("idle_enable", enable, 0);

        // 2: port 4, 3-beat packet
        wr_req = 16'h0010;
        #1;
        check("t2_latency", enable, 0);
        next();
        check("t2_enable", enable, 1);
        check("t2_select", select, 4);
        check("t2_grant", grant_onehot, 16'h0010);
        check("t2_beat1", beat_accept, 1);
        next();
        check("t2_beat2", beat_accept, 1);
        wr_last = 16'h0010;
        #1;
        check("t2_beat3", beat_accept, 1);
        next();
        wr_req  = '0;
        wr_last = '0;
        #1;
        check("t2_idle_enable", enable, 0);
        check("t2_idle_grant", grant_onehot, 0);

        // 3: all ports, 1-beat packets
        do_reset();
        wr_req  = 16'hFFFF;
        wr_last = 16'hFFFF;
        next();
        for (int i = 0; i <= 16; i++) begin
            check("t3_enable", enable, 1);
            check("t3_select", select, i % 16);
            next();
        end

        // 4: ready low mid-packet, port 9 waiting
        do_reset();
        wr_req = 16'h0004;
        next();
        check("t4_select", select, 2);
        next();
        sram_ready = 1'b0;
        wr_req     = 16'h0204;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_hold_select", select, 2);
            check("t4_hold_accept", beat_accept, 0);
            check("t4_hold_enable", enable, 1);
            next();
        end
        sram_ready = 1'b1;
        wr_last    = 16'h0004;
        #1;
        check("t4_last_accept", beat_accept, 1);
        next();
        check("t4_switch_select", select, 9);
        check("t4_switch_grant", grant_onehot, 16'h0200);
        wr_req  = 16'h0200;
        wr_last = 16'h0200;
        next();
        wr_req  = '0;
        wr_last = '0;
        #1;
        check("t4_idle", enable, 0);

        // 5: reset in the middle of a port-3 packet; rr pointer must return to 0
        wr_req = 16'h0008;
        next();
        check("t5_select", select, 3);
        next();
        next();
        next();
        rst = 1'b1;
        #1;
        check("t5_rst_no_accept", beat_accept, 0);
        next();
        check("t5_rst_enable", enable, 0);
        check("t5_rst_grant", grant_onehot, 0);
        rst    = 1'b0;
        wr_req = 16'h1008;
        next();
        check("t5_regrant", select, 3);
        check("t5_regrant_en", enable, 1);
        wr_last = 16'h0008;
        next();
        wr_last = '0;
        check("t5_next_port", select, 12);

        // 6: port 7 never sends last, port 8 waiting
        do_reset();
        wr_req = 16'h0180;
        next();
`ifdef WR_SCHED_TIMEOUT_EN
        for (int b = 1; b <= 8; b++) begin
            check("t6_select7", select, 7);
            check("t6_accept", beat_accept, 1);
            check("t6_no_err", timeout_err, 0);
            next();
        end
        check("t6_release_select", select, 8);
        check("t6_err_pulse", timeout_err, 1);
        next();
        check("t6_err_clear", timeout_err, 0);
`else
        for (int b = 1; b <= 12; b++) begin
            check("t6_hold_select", select, 7);
            check("t6_accept", beat_accept, 1);
            check("t6_no_err", timeout_err, 0);
            next();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
